// File: rtl/idct_transpose_buffer.sv
// idct_transpose_buffer: 8x8 transpose between the IDCT row and column passes.
// Define IDCT_TRANSPOSE_PINGPONG_EN for two-bank ping-pong; default is one bank.
module idct_transpose_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [71:0] in_row,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [71:0] out_col,
    output logic        blk_done
);

`ifdef IDCT_TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [71:0]   mem_q [NB][8];
    logic [NB-1:0] full_q, full_d;
    logic [2:0]    wr_q, wr_d;
    logic [2:0]    rc_q, rc_d;
    logic          blk_done_q, blk_done_d;
    logic          wsel, rsel;
    logic          wr_fire, rd_fire;
    logic          wr_last, rd_last;

    assign in_ready  = ~full_q[wsel];
    assign out_valid = full_q[rsel];
    assign blk_done  = blk_done_q;

    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;
    assign wr_last = wr_fire & (wr_q == 3'd7);
    assign rd_last = rd_fire & (rc_q == 3'd7);

`ifdef IDCT_TRANSPOSE_PINGPONG_EN
    logic wb_q, wb_d;
    logic rb_q, rb_d;

    assign wsel = wb_q;
    assign rsel = rb_q;

    // Bank pointers flip at each block boundary on their own side.
    always_comb begin
        wb_d = wb_q;
        rb_d = rb_q;
        if (wr_last) wb_d = ~wb_q;
        if (rd_last) rb_d = ~rb_q;
    end

    // Bank pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= 1'b0;
            rb_q <= 1'b0;
        end else begin
            wb_q <= wb_d;
            rb_q <= rb_d;
        end
    end
`else
    assign wsel = 1'b0;
    assign rsel = 1'b0;
`endif

    // Row/column counters, bank full flags and end-of-block pulse.
    always_comb begin
        wr_d       = wr_q;
        rc_d       = rc_q;
        full_d     = full_q;
        blk_done_d = rd_last;
        if (wr_fire) wr_d = wr_q + 3'd1;
        if (rd_fire) rc_d = rc_q + 3'd1;
        if (wr_last) full_d[wsel] = 1'b1;
        if (rd_last) full_d[rsel] = 1'b0;
    end

    // Control state; the storage array is deliberately left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= 3'd0;
            rc_q       <= 3'd0;
            full_q     <= '0;
            blk_done_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rc_q       <= rc_d;
            full_q     <= full_d;
            blk_done_q <= blk_done_d;
        end
    end

    // Row storage; a bank is only read once its full flag is set.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wsel][wr_q] <= in_row;
    end

    // Gather element rc of every stored row into one column word.
    always_comb begin
        out_col = '0;
        if (out_valid) begin
            for (int r = 0; r < 8; r++) begin
                out_col[(7 - r) * 9 +: 9] =
                    mem_q[rsel][3'(r)][(7 - 32'(rc_q)) * 9 +: 9];
            end
        end
    end

endmodule
